// File: rtl/lm_sm_pkg.sv
// lm_sm_pkg: shared types and constants for the LM/SM multi-cycle sequencer.
//   state_t         - sequencer state encoding (IDLE, XFER, DONE)
//   LM_SM_NREGS     - default architectural register count (mask width)
//   LM_SM_ADDR_W    - default data-memory word-address width
//   LM_SM_RA_W      - default register-address width (clog2 of NREGS)
//   OPC_LM / OPC_SM - opcodes the main controller decodes to raise start
package lm_sm_pkg;

    localparam int unsigned LM_SM_NREGS  = 8;
    localparam int unsigned LM_SM_ADDR_W = 16;
    localparam int unsigned LM_SM_RA_W   = 3;

    localparam logic [3:0] OPC_LM = 4'b0110;
    localparam logic [3:0] OPC_SM = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lowest_set_bit.sv
// lowest_set_bit: combinational priority encoder, lowest index wins.
//   vec    - input bit vector (N bits)
//   idx    - index of the lowest set bit (0 when vec is all zero)
//   single - high when exactly one bit of vec is set
module lowest_set_bit #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         single
);

    logic found;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[i] && !found) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

    // vec & (vec-1) clears the lowest set bit; zero result means at most one bit
    assign single = (vec != '0) && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: load-multiple / store-multiple transfer sequencer.
// Captures base address and register mask on start, then owns the register
// file and data-memory ports for one word transfer per cycle, lowest register
// first, finishing with a one-cycle done pulse.
//   clk, rst          - clock; asynchronous active-low reset
//   start, is_store   - LM/SM request (sampled in IDLE) and direction (1 = SM)
//   base_addr         - starting word address, captured with start
//   reg_mask          - register select mask, captured with start
//   busy, pc_hold     - datapath ownership and PC-update suppression
//   reg_addr          - register read (SM) / write (LM) address
//   mem_addr          - data-memory word address
//   mem_read          - load strobe (LM)
//   mem_write         - store strobe (SM)
//   reg_write_en      - register write enable for load data (LM)
//   done              - one-cycle completion pulse
module lm_sm_sequencer
    import lm_sm_pkg::*;
#(
    parameter int unsigned NREGS  = LM_SM_NREGS,
    parameter int unsigned ADDR_W = LM_SM_ADDR_W,
    parameter int unsigned RA_W   = LM_SM_RA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [NREGS-1:0]  reg_mask,
    output logic              busy,
    output logic              pc_hold,
    output logic [RA_W-1:0]   reg_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic              reg_write_en,
    output logic              done
);

    state_t            state;
    logic [NREGS-1:0]  mask_q;
    logic [ADDR_W-1:0] addr_q;
    logic              store_q;
    logic [RA_W-1:0]   low_idx;
    logic              last_xfer;

    lowest_set_bit #(
        .N (NREGS),
        .W (RA_W)
    ) u_lsb (
        .vec    (mask_q),
        .idx    (low_idx),
        .single (last_xfer)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            mask_q  <= '0;
            addr_q  <= '0;
            store_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q  <= reg_mask;
                        addr_q  <= base_addr;
                        store_q <= is_store;
                        state   <= (reg_mask != '0) ? XFER : DONE;
                    end
                end
                XFER: begin
                    // drop the register just transferred (lowest set bit)
                    mask_q <= mask_q & (mask_q - NREGS'(1));
                    addr_q <= addr_q + ADDR_W'(1);
                    if (last_xfer) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only, except pc_hold in IDLE, which must
    // follow start within the same cycle so the PC stalls on the start edge.
    always_comb begin
        busy         = 1'b0;
        pc_hold      = 1'b0;
        reg_addr     = '0;
        mem_addr     = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write_en = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                pc_hold = start && rst;
            end
            XFER: begin
                busy     = 1'b1;
                pc_hold  = 1'b1;
                reg_addr = low_idx;
                mem_addr = addr_q;
                if (store_q) begin
                    mem_write = 1'b1;
                end else begin
                    mem_read     = 1'b1;
                    reg_write_en = 1'b1;
                end
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
module tb_lm_sm_sequencer;

    typedef struct packed {
        logic        busy;
        logic        pc_hold;
        logic [2:0]  ra;
        logic [15:0] ma;
        logic        rd;
        logic        wr;
        logic        we;
        logic        done;
    } out_t;

    typedef struct {
        logic        start;
        logic        st;
        logic [15:0] base;
        logic [7:0]  mask;
        out_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [15:0] base_addr;
    logic [7:0]  reg_mask;
    logic        busy;
    logic        pc_hold;
    logic [2:0]  reg_addr;
    logic [15:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write_en;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    vec_t vt[13];

    always #5 clk = ~clk;

    lm_sm_sequencer #(
        .NREGS  (8),
        .ADDR_W (16),
        .RA_W   (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .is_store     (is_store),
        .base_addr    (base_addr),
        .reg_mask     (reg_mask),
        .busy         (busy),
        .pc_hold      (pc_hold),
        .reg_addr     (reg_addr),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write_en (reg_write_en),
        .done         (done)
    );

    function automatic out_t o(input logic b, input logic p, input logic [2:0] ra,
                               input logic [15:0] ma, input logic rd, input logic wr,
                               input logic we, input logic d);
        out_t r;
        r.busy = b; r.pc_hold = p; r.ra = ra; r.ma = ma;
        r.rd = rd; r.wr = wr; r.we = we; r.done = d;
        return r;
    endfunction

    task automatic check(input out_t e, input int id);
        out_t a;
        a = {busy, pc_hold, reg_addr, mem_addr, mem_read, mem_write, reg_write_en, done};
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL vec%0d: got busy=%b pc_hold=%b ra=%0d ma=%h rd=%b wr=%b we=%b done=%b, expected busy=%b pc_hold=%b ra=%0d ma=%h rd=%b wr=%b we=%b done=%b",
                     id, a.busy, a.pc_hold, a.ra, a.ma, a.rd, a.wr, a.we, a.done,
                     e.busy, e.pc_hold, e.ra, e.ma, e.rd, e.wr, e.we, e.done);
        end
    endtask

    // one cycle: drive inputs after the falling edge, sample shortly after
    task automatic cyc(input logic s, input logic st, input logic [15:0] b,
                       input logic [7:0] m, input out_t e, input int id);
        @(negedge clk);
        start = s; is_store = st; base_addr = b; reg_mask = m;
        #1;
        check(e, id);
    endtask

    out_t z;
    logic [15:0] a16;

    initial begin
        z = o(0,0,3'd0,16'h0000,0,0,0,0);

        // LM mask 0000_0101 base 0x0010
        vt[0]  = '{1'b1, 1'b0, 16'h0010, 8'h05, o(0,1,3'd0,16'h0000,0,0,0,0)};
        vt[1]  = '{1'b0, 1'b0, 16'h0000, 8'h00, o(1,1,3'd0,16'h0010,1,0,1,0)};
        vt[2]  = '{1'b0, 1'b0, 16'h0000, 8'h00, o(1,1,3'd2,16'h0011,1,0,1,0)};
        vt[3]  = '{1'b0, 1'b0, 16'h0000, 8'h00, o(1,0,3'd0,16'h0000,0,0,0,1)};
        vt[4]  = '{1'b0, 1'b0, 16'h0000, 8'h00, z};
        // LM with empty mask: done straight after start
        vt[5]  = '{1'b1, 1'b0, 16'h1234, 8'h00, o(0,1,3'd0,16'h0000,0,0,0,0)};
        vt[6]  = '{1'b0, 1'b0, 16'h0000, 8'h00, o(1,0,3'd0,16'h0000,0,0,0,1)};
        vt[7]  = '{1'b0, 1'b0, 16'h0000, 8'h00, z};
        // SM mask 0001_1000 base 0x0100, start held with other values afterwards
        vt[8]  = '{1'b1, 1'b1, 16'h0100, 8'h18, o(0,1,3'd0,16'h0000,0,0,0,0)};
        vt[9]  = '{1'b1, 1'b0, 16'h0500, 8'h01, o(1,1,3'd3,16'h0100,0,1,0,0)};
        vt[10] = '{1'b1, 1'b0, 16'h0500, 8'h01, o(1,1,3'd4,16'h0101,0,1,0,0)};
        vt[11] = '{1'b1, 1'b0, 16'h0500, 8'h01, o(1,0,3'd0,16'h0000,0,0,0,1)};
        vt[12] = '{1'b0, 1'b0, 16'h0000, 8'h00, z};

        rst = 1'b0; start = 1'b0; is_store = 1'b0; base_addr = '0; reg_mask = '0;
        #1;
        check(z, 100);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cyc(vt[i].start, vt[i].st, vt[i].base, vt[i].mask, vt[i].exp, i);
        end

        // SM all registers from 0xFFFE: address wraps through zero
        cyc(1, 1, 16'hFFFE, 8'hFF, o(0,1,3'd0,16'h0000,0,0,0,0), 200);
        for (int i = 0; i < 8; i++) begin
            a16 = 16'hFFFE + 16'(i);
            cyc(0, 0, 16'h0000, 8'h00, o(1,1,3'(i),a16,0,1,0,0), 201 + i);
        end
        cyc(0, 0, 16'h0000, 8'h00, o(1,0,3'd0,16'h0000,0,0,0,1), 209);
        cyc(0, 0, 16'h0000, 8'h00, z, 210);

        // LM mask 1000_0010 base 0x0040; base input changes after start
        cyc(1, 0, 16'h0040, 8'h82, o(0,1,3'd0,16'h0000,0,0,0,0), 300);
        cyc(0, 0, 16'h9999, 8'h00, o(1,1,3'd1,16'h0040,1,0,1,0), 301);
        cyc(0, 0, 16'h9999, 8'h00, o(1,1,3'd7,16'h0041,1,0,1,0), 302);
        cyc(0, 0, 16'h9999, 8'h00, o(1,0,3'd0,16'h0000,0,0,0,1), 303);
        cyc(0, 0, 16'h9999, 8'h00, z, 304);

        // SM mask 0x0F base 0x0200, reset lands during the third transfer
        cyc(1, 1, 16'h0200, 8'h0F, o(0,1,3'd0,16'h0000,0,0,0,0), 400);
        cyc(0, 0, 16'h0000, 8'h00, o(1,1,3'd0,16'h0200,0,1,0,0), 401);
        cyc(0, 0, 16'h0000, 8'h00, o(1,1,3'd1,16'h0201,0,1,0,0), 402);
        @(posedge clk);
        #2;
        check(o(1,1,3'd2,16'h0202,0,1,0,0), 403);
        rst = 1'b0;
        #1;
        check(z, 404);
        cyc(0, 0, 16'h0000, 8'h00, z, 405);
        cyc(0, 0, 16'h0000, 8'h00, z, 406);
        rst = 1'b1;
        cyc(0, 0, 16'h0000, 8'h00, z, 407);
        // fresh LM after reset release
        cyc(1, 0, 16'h0300, 8'h03, o(0,1,3'd0,16'h0000,0,0,0,0), 408);
        cyc(0, 0, 16'h0000, 8'h00, o(1,1,3'd0,16'h0300,1,0,1,0), 409);
        cyc(0, 0, 16'h0000, 8'h00, o(1,1,3'd1,16'h0301,1,0,1,0), 410);
        cyc(0, 0, 16'h0000, 8'h00, o(1,0,3'd0,16'h0000,0,0,0,1), 411);
        cyc(0, 0, 16'h0000, 8'h00, z, 412);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
Multi-cycle sequencer for the IITB RISC load-multiple (LM) and store-multiple (SM) instructions, alongside the single-cycle controller. On a start request it captures the base address and the 8-bit register mask. It then takes ownership of the register-file port and the data-memory port, issuing one word transfer per cycle, lowest register first, while holding the PC. It returns control with a one-cycle done pulse.

Parameters:
NREGS, 8, number of architectural registers; also the mask width.
ADDR_W, 16, data-memory word-address width.
RA_W, 3, register-address width; must equal clog2(NREGS).

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  decoded LM/SM instruction valid; sampled only in IDLE
is_store  in  1  1 = SM, 0 = LM; captured with start
base_addr  in  ADDR_W  RA register value; captured with start
reg_mask  in  NREGS  immediate mask; bit i selects register Ri; captured with start
busy  out  1  sequencer owns the datapath; main controller gates its own writes
pc_hold  out  1  suppresses PC update at the current edge
reg_addr  out  RA_W  register read address (SM) or write address (LM)
mem_addr  out  ADDR_W  data-memory word address
mem_read  out  1  data-memory read strobe (LM)
mem_write  out  1  data-memory write strobe (SM)
reg_write_en  out  1  register-file write enable for load data (LM)
done  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, XFER, DONE, with encoding from the package.
- Reset (rst=0, asynchronous) → IDLE. All outputs 0. Captured mask, address and is_store cleared. Reset mid-XFER abandons the sequence immediately with no further strobes.
- IDLE: busy=0.
  - pc_hold = start, combinational, so the PC does not advance on the start edge.
  - On a start edge: capture mask, base and is_store; next state is XFER if mask≠0, else DONE.
- XFER: busy=1, pc_hold=1.
  - reg_addr = index of the lowest set bit of the remaining mask.
  - mem_addr = current address.
  - LM: mem_read=1 and reg_write_en=1 in the same cycle; data memory reads combinationally.
  - SM: mem_write=1; write data comes from the register-file read port.
  - At the edge: clear that mask bit; address increments by 1 modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
  - When the remaining mask has exactly one bit set, next state is DONE.
- DONE: busy=1, done=1, pc_hold=0 so the PC advances at this edge. All strobes 0. Next state IDLE.
- Latency: start sampled at edge T. Transfers occupy cycles T+1 … T+N, where N = popcount(mask). done is asserted in cycle T+N+1 (N=0 gives done in T+1). Total busy cycles = N+1.
- Captured base is immune to overwrite: an LM whose mask includes the base register still uses captured addresses for every transfer.
- start while not in IDLE is ignored. No queuing, no effect on the sequence.
- Strobes are mutually exclusive. mem_read, mem_write and reg_write_en are never asserted outside XFER. mem_read and mem_write are never asserted together.
- Outputs not in use hold 0. Addresses are 0 when no strobe is active, never high-Z.

Decomposition:
- Package lm_sm_pkg: state enum (IDLE, XFER, DONE); NREGS, ADDR_W, RA_W defaults; LM/SM opcode constants (4'b0110 LM, 4'b0111 SM) for the controller's start decode.
- One sub-module: lowest_set_bit, a combinational NREGS-to-RA_W priority encoder. It outputs the lowest index plus a flag asserted when exactly one bit is set.

Test Plan:
- LM, mask 8'b0000_0101, base 0x0010 → cycle T+1: reg_addr=0, mem_addr=0x0010, mem_read=reg_write_en=1. T+2: reg_addr=2, mem_addr=0x0011. T+3: done=1, pc_hold=0. T+4: busy=0.
- SM, mask 8'hFF, base 0xFFFE → 8 mem_write cycles, reg_addr 0..7, mem_addr 0xFFFE, 0xFFFF, 0x0000 … 0x0005. done at T+9. mem_read never high.
- Mask 8'h00, LM → done at T+1, busy high exactly 1 cycle, no strobes, pc_hold high only in the start cycle.
- start re-pulsed during XFER with a different mask/base → ignored; original sequence completes unchanged.
- LM, mask 8'b1000_0010, base 0x0040, with base_addr input changed to 0x9999 after the start edge → addresses 0x0040, 0x0041 only.
- rst driven low mid-XFER (after 2 of 4 transfers) → outputs 0 asynchronously, state IDLE. After release, a new start runs a full fresh sequence.
